// File: rtl/gate_result_checker_pkg.sv
// Shared definitions for the gate result checker: gate count, bit order of
// the per-gate vectors, and the checker FSM state encoding.
package gate_chk_pkg;

  localparam int NUM_GATES = 7;

  // Bit positions inside every 7-bit expected/observed/mismatch vector
  localparam int GATE_NOT  = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_OR   = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  // FSM state type with fixed, legacy-compatible encodings
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/gate_result_checker_if.sv
// Bundle of the checker's sample inputs and status outputs.
// Optional first-failure capture fields exist only when
// GATE_CHK_FIRST_ERR_EN is defined.
interface gate_chk_if import gate_chk_pkg::*; #(
  parameter int CNT_W = 8
);
  logic                 start;
  logic                 in_valid;
  logic                 in_a;
  logic                 in_b;
  logic                 not_in;
  logic                 and_in;
  logic                 nand_in;
  logic                 or_in;
  logic                 nor_in;
  logic                 xor_in;
  logic                 xnor_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_GATES-1:0] err_mask;
  logic [CNT_W-1:0]     err_count;
  logic [CNT_W-1:0]     sample_count;
`ifdef GATE_CHK_FIRST_ERR_EN
  logic [1:0]           first_err_ab;
  logic [NUM_GATES-1:0] first_err_vec;
  logic [CNT_W-1:0]     first_err_idx;

  modport master (
    output start, in_valid, in_a, in_b, not_in, and_in, nand_in,
           or_in, nor_in, xor_in, xnor_in,
    input  busy, done, pass, err_mask, err_count, sample_count,
           first_err_ab, first_err_vec, first_err_idx
  );
  modport slave (
    input  start, in_valid, in_a, in_b, not_in, and_in, nand_in,
           or_in, nor_in, xor_in, xnor_in,
    output busy, done, pass, err_mask, err_count, sample_count,
           first_err_ab, first_err_vec, first_err_idx
  );
`else
  modport master (
    output start, in_valid, in_a, in_b, not_in, and_in, nand_in,
           or_in, nor_in, xor_in, xnor_in,
    input  busy, done, pass, err_mask, err_count, sample_count
  );
  modport slave (
    input  start, in_valid, in_a, in_b, not_in, and_in, nand_in,
           or_in, nor_in, xor_in, xnor_in,
    output busy, done, pass, err_mask, err_count, sample_count
  );
`endif
endinterface

// File: rtl/gate_result_checker_expect.sv
// gate_expect: reference truth table for the two-input basic-gate block.
// Purely combinational; output bits follow the package gate order.
module gate_expect import gate_chk_pkg::*; (
  input  logic                 i_a,
  input  logic                 i_b,
  output logic [NUM_GATES-1:0] o_expect
);

  // Recompute every gate output from the applied operands
  always_comb begin
    o_expect            = {NUM_GATES{1'b0}};
    o_expect[GATE_NOT]  = ~i_a;
    o_expect[GATE_AND]  = i_a & i_b;
    o_expect[GATE_NAND] = ~(i_a & i_b);
    o_expect[GATE_OR]   = i_a | i_b;
    o_expect[GATE_NOR]  = ~(i_a | i_b);
    o_expect[GATE_XOR]  = i_a ^ i_b;
    o_expect[GATE_XNOR] = ~(i_a ^ i_b);
  end

endmodule

// File: rtl/gate_result_checker.sv
// gate_result_checker: compares the gate block's outputs against the
// reference truth table over a run of NUM_SAMPLES valid beats, collecting
// sticky per-gate flags and a saturating failure count.
// Optional macro GATE_CHK_FIRST_ERR_EN adds first-failure capture.
module gate_result_checker import gate_chk_pkg::*; #(
  parameter int NUM_SAMPLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  gate_chk_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [NUM_GATES-1:0] r_err_mask;
  logic [CNT_W-1:0]     r_err_count;
  logic [CNT_W-1:0]     r_sample_count;
`ifdef GATE_CHK_FIRST_ERR_EN
  logic [1:0]           r_first_err_ab;
  logic [NUM_GATES-1:0] r_first_err_vec;
  logic [CNT_W-1:0]     r_first_err_idx;
`endif

  logic [NUM_GATES-1:0] w_expect;
  logic [NUM_GATES-1:0] w_observed;
  logic [NUM_GATES-1:0] w_mismatch;
  logic [NUM_GATES-1:0] w_mask_nxt;
  logic                 w_any_mis;
  logic                 w_last;

  gate_expect u_expect (
    .i_a      (bus.in_a),
    .i_b      (bus.in_b),
    .o_expect (w_expect)
  );

  // Gather observed gate outputs in package bit order and diff them
  always_comb begin
    w_observed            = {NUM_GATES{1'b0}};
    w_observed[GATE_NOT]  = bus.not_in;
    w_observed[GATE_AND]  = bus.and_in;
    w_observed[GATE_NAND] = bus.nand_in;
    w_observed[GATE_OR]   = bus.or_in;
    w_observed[GATE_NOR]  = bus.nor_in;
    w_observed[GATE_XOR]  = bus.xor_in;
    w_observed[GATE_XNOR] = bus.xnor_in;
    w_mismatch            = w_expect ^ w_observed;
    w_mask_nxt            = r_err_mask | w_mismatch;
    w_any_mis             = (w_mismatch != {NUM_GATES{1'b0}});
    w_last                = (r_sample_count == CNT_LAST);
  end

  // Run FSM plus all status registers; start/in_valid only act in their states
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_err_mask     <= {NUM_GATES{1'b0}};
      r_err_count    <= CNT_ZERO;
      r_sample_count <= CNT_ZERO;
`ifdef GATE_CHK_FIRST_ERR_EN
      r_first_err_ab  <= 2'b00;
      r_first_err_vec <= {NUM_GATES{1'b0}};
      r_first_err_idx <= CNT_ZERO;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state        <= S_RUN;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_err_mask     <= {NUM_GATES{1'b0}};
            r_err_count    <= CNT_ZERO;
            r_sample_count <= CNT_ZERO;
`ifdef GATE_CHK_FIRST_ERR_EN
            r_first_err_ab  <= 2'b00;
            r_first_err_vec <= {NUM_GATES{1'b0}};
            r_first_err_idx <= CNT_ZERO;
`endif
          end else begin
            r_state <= r_state;
          end
        end
        S_RUN: begin
          if (bus.in_valid) begin
            r_err_mask     <= w_mask_nxt;
            r_sample_count <= r_sample_count + CNT_W'(1);
            if (w_any_mis && (r_err_count != CNT_ONES)) begin
              r_err_count <= r_err_count + CNT_W'(1);
            end else begin
              r_err_count <= r_err_count;
            end
`ifdef GATE_CHK_FIRST_ERR_EN
            // err_count is still zero only until the first failing beat
            if (w_any_mis && (r_err_count == CNT_ZERO)) begin
              r_first_err_ab  <= {bus.in_a, bus.in_b};
              r_first_err_vec <= w_mismatch;
              r_first_err_idx <= r_sample_count;
            end else begin
              r_first_err_ab  <= r_first_err_ab;
            end
`endif
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_mask_nxt == {NUM_GATES{1'b0}});
            end else begin
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.err_mask     = r_err_mask;
  assign bus.err_count    = r_err_count;
  assign bus.sample_count = r_sample_count;
`ifdef GATE_CHK_FIRST_ERR_EN
  assign bus.first_err_ab  = r_first_err_ab;
  assign bus.first_err_vec = r_first_err_vec;
  assign bus.first_err_idx = r_first_err_idx;
`endif

endmodule
